// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: signal bundle between the fetch/sequencing controller and
// the datapath/memory side.
//   master (controller): drives imem_req, ir_ld, dmem_req, dmem_we, rf_we,
//                        pc_ld, pc_sel, fault, state; samples run, imem_ack,
//                        opcode, funct, zero, dmem_ack.
//   slave  (datapath/memories): the mirror image.
interface pc_fetch_ctrl_if;
  logic       run;
  logic       imem_req;
  logic       imem_ack;
  logic       ir_ld;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ack;
  logic       rf_we;
  logic       pc_ld;
  logic [1:0] pc_sel;
  logic       fault;
  logic [2:0] state;

  modport master (
    input  run, imem_ack, opcode, funct, zero, dmem_ack,
    output imem_req, ir_ld, dmem_req, dmem_we, rf_we, pc_ld, pc_sel, fault, state
  );

  modport slave (
    output run, imem_ack, opcode, funct, zero, dmem_ack,
    input  imem_req, ir_ld, dmem_req, dmem_we, rf_we, pc_ld, pc_sel, fault, state
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: multi-cycle instruction sequencer for a small MIPS-like core.
// Walks IDLE -> FETCH -> DECODE -> EXEC [-> MEM] [-> WB] and produces
// single-cycle registered strobes for the IR, PC and register file, plus
// instruction/data memory requests with an ack timeout that faults to HALT.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - pc_fetch_ctrl_if.master (run, memory handshakes, decode fields,
//          strobes, pc_sel, fault, debug state)
// Parameters:
//   ACK_TIMEOUT - ack-less cycles tolerated in FETCH/MEM (2..255)
//   START_SEL   - pc_sel value whenever pc_ld is not being driven
module pc_fetch_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter logic [1:0]  START_SEL   = 2'b00
) (
  input  logic             clk,
  input  logic             rst,
  pc_fetch_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [7:0] LP_TIMEOUT = 8'(ACK_TIMEOUT);

  state_t     r_state;
  logic [7:0] r_wait_cnt;
  logic [5:0] r_opc;
  logic [5:0] r_fn;
  logic       r_imem_req;
  logic       r_ir_ld;
  logic       r_dmem_req;
  logic       r_dmem_we;
  logic       r_rf_we;
  logic       r_pc_ld;
  logic [1:0] r_pc_sel;
  logic       r_fault;

  logic [7:0] w_wait_next;
  logic       w_timeout;
  logic       w_legal;

  // The cycle that would be ack-less number ACK_TIMEOUT; an ack in that same
  // cycle is checked first and therefore wins.
  assign w_wait_next = r_wait_cnt + 8'd1;
  assign w_timeout   = (w_wait_next == LP_TIMEOUT);

  always_comb begin
    w_legal = 1'b0;
    case (bus.opcode)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW: w_legal = 1'b1;
      default:                                              w_legal = 1'b0;
    endcase
  end

  // Strobes are registered: they are high in the cycle after the deciding
  // edge, so the falling-edge PC/IR registers see a settled level. When the
  // instruction finishes, the next state (FETCH/IDLE) is chosen on that same
  // edge, so the pc_ld cycle overlaps the first FETCH cycle -- except WB,
  // where the strobes are entered with the state and run is sampled on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_opc      <= '0;
      r_fn       <= '0;
      r_imem_req <= 1'b0;
      r_ir_ld    <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_rf_we    <= 1'b0;
      r_pc_ld    <= 1'b0;
      r_pc_sel   <= START_SEL;
      r_fault    <= 1'b0;
    end else begin
      r_ir_ld  <= 1'b0;
      r_rf_we  <= 1'b0;
      r_pc_ld  <= 1'b0;
      r_pc_sel <= START_SEL;

      case (r_state)
        IDLE: begin
          if (bus.run) begin
            r_state    <= FETCH;
            r_imem_req <= 1'b1;
            r_wait_cnt <= '0;
          end
        end

        FETCH: begin
          if (bus.imem_ack) begin
            r_imem_req <= 1'b0;
            r_ir_ld    <= 1'b1;
            r_state    <= DECODE;
          end else if (w_timeout) begin
            r_imem_req <= 1'b0;
            r_fault    <= 1'b1;
            r_state    <= HALT;
          end else begin
            r_wait_cnt <= w_wait_next;
          end
        end

        DECODE: begin
          r_opc <= bus.opcode;
          r_fn  <= bus.funct;
          if (w_legal) begin
            r_state <= EXEC;
          end else begin
            r_fault <= 1'b1;
            r_state <= HALT;
          end
        end

        EXEC: begin
          case (r_opc)
            OP_LW, OP_SW: begin
              r_state    <= MEM;
              r_dmem_req <= 1'b1;
              r_dmem_we  <= (r_opc == OP_SW);
              r_wait_cnt <= '0;
            end
            OP_RTYPE: begin
              if (r_fn == FN_JR) begin
                r_pc_ld    <= 1'b1;
                r_pc_sel   <= 2'b11;
                r_state    <= bus.run ? FETCH : IDLE;
                r_imem_req <= bus.run;
                r_wait_cnt <= '0;
              end else begin
                r_rf_we  <= 1'b1;
                r_pc_ld  <= 1'b1;
                r_pc_sel <= 2'b00;
                r_state  <= WB;
              end
            end
            OP_J, OP_JAL: begin
              r_pc_ld    <= 1'b1;
              r_pc_sel   <= 2'b10;
              r_rf_we    <= (r_opc == OP_JAL);
              r_state    <= bus.run ? FETCH : IDLE;
              r_imem_req <= bus.run;
              r_wait_cnt <= '0;
            end
            OP_BEQ, OP_BNE: begin
              r_pc_ld    <= 1'b1;
              r_pc_sel   <= ((r_opc == OP_BEQ) == bus.zero) ? 2'b01 : 2'b00;
              r_state    <= bus.run ? FETCH : IDLE;
              r_imem_req <= bus.run;
              r_wait_cnt <= '0;
            end
            default: begin
              r_fault <= 1'b1;
              r_state <= HALT;
            end
          endcase
        end

        MEM: begin
          if (bus.dmem_ack) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_pc_ld    <= 1'b1;
            r_pc_sel   <= 2'b00;
            if (r_opc == OP_SW) begin
              r_state    <= bus.run ? FETCH : IDLE;
              r_imem_req <= bus.run;
              r_wait_cnt <= '0;
            end else begin
              r_rf_we <= 1'b1;
              r_state <= WB;
            end
          end else if (w_timeout) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_fault    <= 1'b1;
            r_state    <= HALT;
          end else begin
            r_wait_cnt <= w_wait_next;
          end
        end

        WB: begin
          r_state    <= bus.run ? FETCH : IDLE;
          r_imem_req <= bus.run;
          r_wait_cnt <= '0;
        end

        HALT: r_state <= HALT;

        default: r_state <= HALT;
      endcase
    end
  end

  assign bus.imem_req = r_imem_req;
  assign bus.ir_ld    = r_ir_ld;
  assign bus.dmem_req = r_dmem_req;
  assign bus.dmem_we  = r_dmem_we;
  assign bus.rf_we    = r_rf_we;
  assign bus.pc_ld    = r_pc_ld;
  assign bus.pc_sel   = r_pc_sel;
  assign bus.fault    = r_fault;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed bench for pc_fetch_ctrl. Stimulus pushes the
// expected strobe events (ir_ld / pc_ld / rf_we with pc_sel and state) into a
// queue; a negedge monitor pops and compares whenever any strobe is high.
// Handshake, timeout, halt and reset behaviour is checked inline.
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if bus();

  pc_fetch_ctrl #(.ACK_TIMEOUT(16), .START_SEL(2'b00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       ir;
    logic       pc;
    logic       rf;
    logic [1:0] sel;
    logic [2:0] st;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_act;
  ev_t         mon_exp;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_we     = 0;
  int unsigned we0;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BAD = 6'b111111;

  function automatic ev_t ev(input logic ir, input logic pc, input logic rf,
                             input logic [1:0] sel, input logic [2:0] st);
    return {ir, pc, rf, sel, st};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present the instruction after `waits` ack-less FETCH cycles; ends in DECODE.
  task automatic fetch(input int unsigned waits, input logic [5:0] op, input logic [5:0] fn);
    for (int unsigned i = 0; i < waits; i++) begin
      bus.imem_ack = 1'b0;
      tick();
    end
    bus.imem_ack = 1'b1;
    bus.opcode   = op;
    bus.funct    = fn;
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 2'b00, 3'd2));
    tick();
    bus.imem_ack = 1'b0;
    chk("fetch_to_decode", 32'(bus.state), 32'd2);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.dmem_we) n_we++;
    if (!rst && (bus.ir_ld || bus.pc_ld || bus.rf_we)) begin
      mon_act = {bus.ir_ld, bus.pc_ld, bus.rf_we, bus.pc_sel, bus.state};
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: got 0x%0h expected no strobe", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("strobe_event", 32'(mon_act), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.run = 1'b0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_outs", 32'({bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_ld,
                         bus.rf_we, bus.pc_ld, bus.fault}), 32'd0);
    chk("rst_pc_sel", 32'(bus.pc_sel), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_hold", 32'(bus.state), 32'd0);

    // acks outside FETCH/MEM are ignored
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
    tick();
    chk("ack_ignored_idle", 32'({bus.state, bus.imem_req, bus.dmem_req}), 32'd0);
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;

    bus.run = 1'b1;
    tick();
    chk("fetch_entry", 32'({bus.state, bus.imem_req}), 32'({3'd1, 1'b1}));

    // beq taken, imem_ack after 3 ack-less cycles: 4 FETCH + DECODE + EXEC
    fetch(3, OP_BEQ, 6'd0);
    bus.zero = 1'b1;
    tick();
    chk("beq_exec", 32'(bus.state), 32'd3);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 2'b01, 3'd1));
    tick();
    chk("beq_refetch", 32'({bus.state, bus.imem_req}), 32'({3'd1, 1'b1}));

    // lw, dmem_ack after 2 cycles
    fetch(0, OP_LW, 6'd0);
    tick();
    tick();
    chk("lw_mem", 32'({bus.state, bus.dmem_req, bus.dmem_we}), 32'({3'd4, 1'b1, 1'b0}));
    we0 = n_we;
    tick();
    tick();
    bus.dmem_ack = 1'b1;
    exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 2'b00, 3'd5));
    tick();
    bus.dmem_ack = 1'b0;
    chk("lw_wb", 32'({bus.state, bus.dmem_req}), 32'({3'd5, 1'b0}));
    tick();
    chk("lw_no_we", n_we - we0, 32'd0);
    chk("lw_refetch", 32'(bus.state), 32'd1);

    // sw
    fetch(1, OP_SW, 6'd0);
    tick();
    tick();
    chk("sw_mem", 32'({bus.state, bus.dmem_req, bus.dmem_we}), 32'({3'd4, 1'b1, 1'b1}));
    bus.dmem_ack = 1'b1;
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 2'b00, 3'd1));
    tick();
    bus.dmem_ack = 1'b0;
    chk("sw_done", 32'({bus.state, bus.dmem_req, bus.dmem_we}), 32'({3'd1, 1'b0, 1'b0}));

    // R-type add -> WB
    fetch(0, OP_R, 6'b100000);
    tick();
    exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 2'b00, 3'd5));
    tick();
    chk("add_wb", 32'(bus.state), 32'd5);
    tick();
    chk("add_refetch", 32'(bus.state), 32'd1);

    // jr
    fetch(0, OP_R, 6'b001000);
    tick();
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 2'b11, 3'd1));
    tick();

    // jal
    fetch(2, OP_JAL, 6'd0);
    tick();
    exp_q.push_back(ev(1'b0, 1'b1, 1'b1, 2'b10, 3'd1));
    tick();

    // bne not taken, then taken
    fetch(0, OP_BNE, 6'd0);
    bus.zero = 1'b1;
    tick();
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 2'b00, 3'd1));
    tick();
    fetch(0, OP_BNE, 6'd0);
    bus.zero = 1'b0;
    tick();
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 2'b01, 3'd1));
    tick();

    // j with run dropped in DECODE: completes, then IDLE
    fetch(0, OP_J, 6'd0);
    bus.run = 1'b0;
    tick();
    chk("j_not_aborted", 32'(bus.state), 32'd3);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 2'b10, 3'd0));
    tick();
    chk("j_to_idle", 32'({bus.state, bus.imem_req}), 32'd0);
    tick();
    chk("idle_after_j", 32'(bus.state), 32'd0);

    // ack on the 16th FETCH cycle wins
    bus.run = 1'b1;
    tick();
    fetch(15, OP_J, 6'd0);
    chk("late_ack_no_fault", 32'(bus.fault), 32'd0);
    tick();
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 2'b10, 3'd1));
    tick();

    // imem_ack withheld: HALT after exactly 16 cycles
    bus.imem_ack = 1'b0;
    repeat (15) tick();
    chk("to_cycle16", 32'({bus.state, bus.fault, bus.imem_req}), 32'({3'd1, 1'b0, 1'b1}));
    tick();
    chk("to_halt", 32'({bus.state, bus.fault, bus.imem_req}), 32'({3'd6, 1'b1, 1'b0}));
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
    repeat (3) tick();
    chk("halt_sticky", 32'({bus.state, bus.fault, bus.imem_req, bus.dmem_req}),
        32'({3'd6, 1'b1, 1'b0, 1'b0}));
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("halt_rst_clears", 32'({bus.state, bus.fault}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("restart_fetch", 32'(bus.state), 32'd1);

    // illegal opcode -> HALT, no pc_ld
    fetch(0, OP_BAD, 6'd0);
    tick();
    chk("illegal_halt", 32'({bus.state, bus.fault}), 32'({3'd6, 1'b1}));
    repeat (2) tick();
    chk("illegal_stays", 32'({bus.state, bus.pc_ld, bus.rf_we}), 32'({3'd6, 1'b0, 1'b0}));
    rst = 1'b1;
    #1;
    chk("illegal_rst", 32'({bus.state, bus.fault}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("illegal_restart", 32'(bus.state), 32'd1);

    // reset pulse during MEM drops dmem_req asynchronously
    fetch(0, OP_LW, 6'd0);
    tick();
    tick();
    chk("pre_rst_mem", 32'({bus.state, bus.dmem_req}), 32'({3'd4, 1'b1}));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mem_drop", 32'({bus.dmem_req, bus.imem_req, bus.pc_ld}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mem_idle", 32'(bus.state), 32'd0);
    tick();
    chk("rst_mem_restart", 32'({bus.state, bus.imem_req}), 32'({3'd1, 1'b1}));
    tick();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 16, meaning the maximum cycles to wait for a memory ack before faulting (range 2..255).
REQ-002 The block SHALL have parameter START_SEL, default 2'b00, meaning the pc_sel value driven while idle.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-005 The block SHALL have port run, input, 1, a level that enables instruction sequencing.
REQ-006 The block SHALL have port imem_req, output, 1, the instruction fetch request.
REQ-007 The block SHALL have port imem_ack, input, 1, the instruction fetch completion.
REQ-008 The block SHALL have port ir_ld, output, 1, a one-cycle instruction-register load strobe.
REQ-009 The block SHALL have port opcode, input, 6, the IR[31:26] field.
REQ-010 The block SHALL have port funct, input, 6, the IR[5:0] field.
REQ-011 The block SHALL have port zero, input, 1, the ALU zero flag, valid in EXEC.
REQ-012 The block SHALL have port dmem_req, output, 1, the data memory request.
REQ-013 The block SHALL have port dmem_we, output, 1, the data write enable.
REQ-014 The block SHALL have port dmem_ack, input, 1, the data memory completion.
REQ-015 The block SHALL have port rf_we, output, 1, a one-cycle register-file write strobe.
REQ-016 The block SHALL have port pc_ld, output, 1, a one-cycle PC load strobe.
REQ-017 The block SHALL have port pc_sel, output, 2, the PC source: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = register (jr).
REQ-018 The block SHALL have port fault, output, 1, a sticky timeout/illegal-opcode flag.
REQ-019 The block SHALL have port state, output, 3, the current FSM state, for debug.

Function
REQ-020 The FSM states SHALL be encoded IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
REQ-021 IDLE SHALL go to FETCH when run=1, otherwise stay in IDLE.
REQ-022 FETCH SHALL hold imem_req=1 until the cycle imem_ack=1, then assert ir_ld for exactly that cycle and go to DECODE.
REQ-023 DECODE SHALL last one cycle and go to EXEC, or go to HALT and set fault if the opcode is not in {000000, 000010, 000011, 000100, 000101, 100011, 101011}.
REQ-024 EXEC for beq (000100) and bne (000101) SHALL set pc_sel=01 if the branch is taken (beq: zero=1; bne: zero=0), else 00, assert pc_ld, and go to IDLE-or-FETCH per REQ-029.
REQ-025 EXEC for j (000010) SHALL set pc_sel=10 and assert pc_ld; jal (000011) SHALL additionally assert rf_we in the same cycle.
REQ-026 EXEC for R-type with funct=001000 (jr) SHALL set pc_sel=11 and assert pc_ld; any other R-type SHALL go to WB.
REQ-027 EXEC for lw/sw SHALL go to MEM; MEM SHALL hold dmem_req=1 (dmem_we=1 for sw only) until dmem_ack=1; then sw SHALL assert pc_ld with pc_sel=00 and lw SHALL go to WB.
REQ-028 WB SHALL assert rf_we and pc_ld with pc_sel=00 for one cycle.
REQ-029 After any pc_ld cycle the FSM SHALL go to FETCH if run=1, else to IDLE; run=0 SHALL never abort an instruction already past FETCH.
REQ-030 pc_ld, ir_ld and rf_we SHALL be registered, single-cycle, and high for exactly one clock per instruction, so the PC register (falling-edge load) samples a stable level.
REQ-031 pc_sel SHALL be registered and valid in the same cycle as pc_ld; otherwise it SHALL equal START_SEL.
REQ-032 An 8-bit wait counter SHALL clear on entry to FETCH/MEM and count ack-less cycles; on reaching ACK_TIMEOUT the FSM SHALL go to HALT, drop the request, and set fault.
REQ-033 An ack arriving in the same cycle the counter reaches ACK_TIMEOUT SHALL win (no fault).
REQ-034 HALT SHALL be left only by reset; all strobes and requests SHALL be 0 in HALT.
REQ-035 An ack seen outside the matching wait state SHALL be ignored.

Reset
REQ-036 While rst=1, all outputs SHALL be 0 except pc_sel=START_SEL and state=IDLE; the counter and fault SHALL be cleared.
REQ-037 Reset asserted mid-transaction SHALL drop the requests immediately (asynchronously), with no pc_ld pulse.

Verification
REQ-038 Bench: run=1, beq, zero=1, imem_ack after 3 cycles -> exactly one ir_ld, then pc_ld=1 with pc_sel=01 at the EXEC cycle; the instruction takes 6 cycles.
REQ-039 Bench: lw, dmem_ack after 2 cycles -> dmem_we=0 throughout, WB has rf_we=1, pc_ld=1, pc_sel=00.
REQ-040 Bench: sw -> dmem_we=1 with dmem_req, pc_ld pulses after the ack, and rf_we never asserts.
REQ-041 Bench: imem_ack withheld -> state=HALT and fault=1 after exactly 16 cycles; an ack on cycle 16 gives no fault.
REQ-042 Bench: opcode 111111 -> HALT with fault=1 and no pc_ld; then rst -> state=0, fault=0.
REQ-043 Bench: rst pulse during MEM -> dmem_req=0 before the next rising edge; with run=1 held, the FSM restarts in FETCH.
